seq_frame_scan_ctrl: RTL

Frame-level controller that sequences a programmable serial pattern matcher, the generalised form of our fixed 1011 detector. It accepts parallel data words over a valid/ready handshake and serialises each word MSB-first into the matcher at one bit per clock. It also counts pattern hits per frame and raises a sticky interrupt when a programmed hit threshold is reached. It sits between the word-wide stream fabric and the interrupt/status logic.

---
 rtl/seq_frame_scan_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/seq_frame_scan_ctrl.sv
// seq_frame_scan_ctrl
// Frame-level sequencer for a programmable serial pattern matcher. Words are
// accepted over a valid/ready handshake and shifted MSB-first into a history
// register at one bit per clock. Pattern hits are counted per frame, and a
// sticky interrupt is raised when the count reaches a programmed threshold.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   cfg_we            config write strobe (ignored while busy)
//   cfg_pattern       pattern; bit 0 is the last bit of the sequence
//   cfg_len           pattern length (0 -> 1, clipped to PAT_MAX)
//   cfg_overlap       1 = overlapping detection, 0 = non-overlapping
//   cfg_thresh        irq threshold, 0 disables irq
//   in_valid/in_ready word handshake
//   in_data/in_last   word payload and end-of-frame flag
//   irq_clr           clears irq (a simultaneous set wins)
//   match_pulse       one-cycle pulse per match
//   match_count       saturating per-frame match count
//   irq               sticky threshold interrupt
//   busy              frame in progress
//   done              one-cycle end-of-frame pulse
module seq_frame_scan_ctrl #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic               irq_clr,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               irq,
  output logic               busy,
  output logic               done
);

  localparam int unsigned IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned FILL_W = $clog2(PAT_MAX + 1);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_MAX);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PAT_MAX-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pulse_q, pulse_d;
  logic                irq_q, irq_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [PAT_MAX-1:0]  cfg_pat_q, cfg_pat_d;
  logic [3:0]          cfg_len_q, cfg_len_d;
  logic                cfg_ovl_q, cfg_ovl_d;
  logic [CNT_W-1:0]    cfg_thr_q, cfg_thr_d;

  logic [FILL_W-1:0]   eff_len;
  logic [PAT_MAX-1:0]  len_mask;
  logic                shift_bit;
  logic [PAT_MAX-1:0]  hist_sh;
  logic [FILL_W-1:0]   fill_inc;
  logic [CNT_W-1:0]    cnt_inc;
  logic                hit;
  logic                irq_set;

  // Effective pattern length and the compare mask covering its low bits
  always_comb begin
    if (cfg_len_q == 4'd0) begin
      eff_len = FILL_W'(1);
    end else if (32'(cfg_len_q) > PAT_MAX) begin
      eff_len = FILL_MAX;
    end else begin
      eff_len = FILL_W'(cfg_len_q);
    end
    len_mask = '0;
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      len_mask[i] = (i < 32'(eff_len));
    end
  end

  // Candidate shift result for the current bit, used only in SHIFT
  always_comb begin
    shift_bit = word_q[idx_q];
    hist_sh   = {hist_q[PAT_MAX-2:0], shift_bit};
    fill_inc  = (fill_q >= FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    hit       = (fill_inc >= eff_len) &&
                ((hist_sh & len_mask) == (cfg_pat_q & len_mask));
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    last_d    = last_q;
    idx_d     = idx_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    done_d    = 1'b0;
    irq_set   = 1'b0;
    cfg_pat_d = cfg_pat_q;
    cfg_len_d = cfg_len_q;
    cfg_ovl_d = cfg_ovl_q;
    cfg_thr_d = cfg_thr_q;

    // Configuration is frozen for the duration of a frame
    if (cfg_we && !active_q) begin
      cfg_pat_d = cfg_pattern;
      cfg_len_d = cfg_len;
      cfg_ovl_d = cfg_overlap;
      cfg_thr_d = cfg_thresh;
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          last_d  = in_last;
          idx_d   = IDX_TOP;
          state_d = S_SHIFT;
          // First word of a frame starts from a clean history and count
          if (!active_q) begin
            fill_d   = '0;
            hist_d   = '0;
            cnt_d    = '0;
            active_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        hist_d = hist_sh;
        fill_d = fill_inc;
        if (hit) begin
          pulse_d = 1'b1;
          cnt_d   = cnt_inc;
          // Non-overlapping mode: matched bits may not seed the next hit
          if (!cfg_ovl_q) begin
            fill_d = '0;
          end
          if ((cfg_thr_q != '0) && (cnt_inc == cfg_thr_q)) begin
            irq_set = 1'b1;
          end
        end
        if (idx_q == '0) begin
          state_d = last_q ? S_DONE : S_IDLE;
          done_d  = last_q;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    irq_d   = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      active_q  <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      irq_q     <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      cfg_pat_q <= '0;
      cfg_len_q <= 4'd1;
      cfg_ovl_q <= 1'b1;
      cfg_thr_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      irq_q     <= irq_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      cfg_pat_q <= cfg_pat_d;
      cfg_len_q <= cfg_len_d;
      cfg_ovl_q <= cfg_ovl_d;
      cfg_thr_q <= cfg_thr_d;
    end
  end

  assign in_ready    = ready_q;
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign irq         = irq_q;
  assign busy        = active_q;
  assign done        = done_q;

endmodule
